// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter: FSM state encoding, default
// datapath widths and a counter-width helper.
package sprite_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        EMIT  = ST_EMIT,
        DONE  = ST_DONE
    } state_t;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_COLOR_W = 3;

    // A 1-wide dimension still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Column/row walker for the sprite: holds the pixel counters, applies the
// flip mapping and produces the row-major sprite ROM address.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int ADDR_W   = 10,
    parameter int COL_W    = cnt_width(SPRITE_W),
    parameter int ROW_W    = cnt_width(SPRITE_H)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    input  logic              flip_h,
    input  logic              flip_v,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPRITE_H - 1);

    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [COL_W-1:0] src_col;
    logic [ROW_W-1:0] src_row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (clear) begin
            col_next = '0;
            row_next = '0;
        end else if (advance) begin
            if (col_reg == COL_MAX) begin
                col_next = '0;
                row_next = row_reg + ROW_W'(1);
            end else begin
                col_next = col_reg + COL_W'(1);
            end
        end
    end

    // Counters always walk the screen in row-major order; flipping only
    // changes which source texel feeds the current screen position.
    always_comb begin
        src_col  = flip_h ? (COL_MAX - col_reg) : col_reg;
        src_row  = flip_v ? (ROW_MAX - row_reg) : row_reg;
        rom_addr = ADDR_W'(src_row) * ADDR_W'(SPRITE_W) + ADDR_W'(src_col);
        last     = (col_reg == COL_MAX) && (row_reg == ROW_MAX);
    end

    assign col = col_reg;
    assign row = row_reg;

endmodule

// File: rtl/sprite_blitter.sv
// Walks a WxH sprite from ROM and emits one framebuffer plot per visible
// pixel, with flips, colour-key transparency, edge clipping and backpressure.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int ADDR_W    = 10,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int KEY_COLOR = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               flip_h,
    input  logic               flip_v,
    input  logic               key_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               plot_out,
    input  logic               plot_ready,
    output logic [COORD_W-1:0] x_pix,
    output logic [COORD_W-1:0] y_pix,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               draw_done
);

    localparam int COL_W = cnt_width(SPRITE_W);
    localparam int ROW_W = cnt_width(SPRITE_H);
    localparam logic [COORD_W:0]   X_LIMIT = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0]   Y_LIMIT = (COORD_W+1)'(SCREEN_H);
    localparam logic [COLOR_W-1:0] KEY     = COLOR_W'(KEY_COLOR);

    state_t state_reg, state_next;

    logic [COORD_W-1:0] x_lat_reg, y_lat_reg;
    logic               flip_h_reg, flip_v_reg, key_en_reg;
    logic [COORD_W:0]   x_sum_reg, y_sum_reg;
    logic [COLOR_W-1:0] color_reg;
    logic               first_reg;

    logic               clear, advance, last;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [COLOR_W-1:0] pix_color;
    logic               visible;

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .advance  (advance),
        .flip_h   (flip_h_reg),
        .flip_v   (flip_v_reg),
        .col      (col),
        .row      (row),
        .rom_addr (rom_addr),
        .last     (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_lat_reg  <= '0;
            y_lat_reg  <= '0;
            flip_h_reg <= 1'b0;
            flip_v_reg <= 1'b0;
            key_en_reg <= 1'b0;
            x_sum_reg  <= '0;
            y_sum_reg  <= '0;
            color_reg  <= '0;
            first_reg  <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                x_lat_reg  <= x_pos;
                y_lat_reg  <= y_pos;
                flip_h_reg <= flip_h;
                flip_v_reg <= flip_v;
                key_en_reg <= key_en;
            end
            // Extra bit keeps the carry so a wrapped coordinate clips.
            if (state_reg == FETCH) begin
                x_sum_reg <= {1'b0, x_lat_reg} + (COORD_W+1)'(col);
                y_sum_reg <= {1'b0, y_lat_reg} + (COORD_W+1)'(row);
            end
            first_reg <= (state_reg == FETCH);
            if (first_reg) begin
                color_reg <= pix_color;
            end
        end
    end

    // ROM data arrives in the first EMIT cycle; later stall cycles replay
    // the captured copy so colour stays stable regardless of ROM behaviour.
    always_comb begin
        pix_color = first_reg ? rom_data : color_reg;
        visible   = !(key_en_reg && (pix_color == KEY)) &&
                    (x_sum_reg < X_LIMIT) && (y_sum_reg < Y_LIMIT);
    end

    always_comb begin
        state_next = state_reg;
        clear      = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = EMIT;
            end
            EMIT: begin
                if (!visible || plot_ready) begin
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign plot_out  = (state_reg == EMIT) && visible;
    assign busy      = (state_reg != IDLE);
    assign draw_done = (state_reg == DONE);
    assign x_pix     = x_sum_reg[COORD_W-1:0];
    assign y_pix     = y_sum_reg[COORD_W-1:0];
    assign color     = pix_color;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a 4x4 sprite and a synchronous ROM.
// Cycle numbers count the cycle in which start is sampled as cycle 1.
module tb_sprite_blitter;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 10;
    localparam int KW = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n, start, flip_h, flip_v, key_en, plot_ready;
    logic [CW-1:0] x_pos, y_pos, x_pix, y_pix;
    logic [AW-1:0] rom_addr;
    logic [KW-1:0] rom_data, color;
    logic          plot_out, busy, draw_done;

    logic [KW-1:0] rom_mem [W*H];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    sprite_blitter #(
        .SPRITE_W (W), .SPRITE_H (H), .COORD_W (CW), .COLOR_W (KW),
        .ADDR_W (AW), .SCREEN_W (640), .SCREEN_H (480), .KEY_COLOR (0)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start),
        .x_pos (x_pos), .y_pos (y_pos),
        .flip_h (flip_h), .flip_v (flip_v), .key_en (key_en),
        .rom_addr (rom_addr), .rom_data (rom_data),
        .plot_out (plot_out), .plot_ready (plot_ready),
        .x_pix (x_pix), .y_pix (y_pix), .color (color),
        .busy (busy), .draw_done (draw_done)
    );

    // Accepted plots and plot_out-high cycles, sampled mid-cycle.
    logic [CW-1:0] mx[$];
    logic [CW-1:0] my[$];
    logic [KW-1:0] mc[$];
    int            plot_hi = 0;

    always @(negedge clk) begin
        if (reset_n === 1'b1 && plot_out === 1'b1) begin
            plot_hi++;
            if (plot_ready === 1'b1) begin
                mx.push_back(x_pix);
                my.push_back(y_pix);
                mc.push_back(color);
            end
        end
    end

    task automatic load_rom(input int mode);
        for (int i = 0; i < W*H; i++)
            rom_mem[i] = (mode == 1 && i % 2 == 0) ? KW'(0) : KW'(i % 7 + 1);
    endtask

    task automatic do_draw(input int x, input int y, input bit fh, input bit fv, input bit ke,
                           output int cyc, output int n, output int nhi, output int base,
                           output logic [AW-1:0] first_addr);
        int hi0;
        base = mx.size();
        hi0  = plot_hi;
        @(posedge clk); #1;
        x_pos = CW'(x); y_pos = CW'(y);
        flip_h = fh; flip_v = fv; key_en = ke; plot_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        @(negedge clk);
        first_addr = rom_addr;
        while (draw_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n   = mx.size() - base;
        nhi = plot_hi - hi0;
        $display("[TB] draw (%0d,%0d) fh=%0d fv=%0d key=%0d: %0d plots, done at cycle %0d",
                 x, y, fh, fv, ke, n, cyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; x_pos = '0; y_pos = '0;
        flip_h = 1'b0; flip_v = 1'b0; key_en = 1'b0; plot_ready = 1'b1;
        load_rom(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({plot_out, busy, draw_done} !== 3'b000 || rom_addr !== '0 ||
            x_pix !== '0 || y_pix !== '0 || color !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got plot=%b busy=%b done=%b addr=%0d x=%0d y=%0d c=%0d required all zero",
                     plot_out, busy, draw_done, rom_addr, x_pix, y_pix, color);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || draw_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, draw_done);
        end
    endtask

    task automatic test_basic();
        int cyc, n, nhi, base;
        logic [AW-1:0] fa;
        logic [CW-1:0] gx, gy;
        logic [KW-1:0] gc;
        load_rom(0);
        do_draw(10, 20, 0, 0, 0, cyc, n, nhi, base, fa);
        tests_run++;
        if (cyc != 34 || n != 16 || fa !== AW'(0)) begin
            tests_failed++;
            $display("FAIL basic_summary: got cycle=%0d plots=%0d addr0=%0d required 34 16 0", cyc, n, fa);
        end
        for (int k = 0; k < 16; k++) begin
            gx = (k < n) ? mx[base+k] : 'x;
            gy = (k < n) ? my[base+k] : 'x;
            gc = (k < n) ? mc[base+k] : 'x;
            tests_run++;
            if (gx !== CW'(10 + k % 4) || gy !== CW'(20 + k / 4) || gc !== KW'(k % 7 + 1)) begin
                tests_failed++;
                $display("FAIL basic_pix%0d: got (%0d,%0d) c%0d required (%0d,%0d) c%0d",
                         k, gx, gy, gc, 10 + k % 4, 20 + k / 4, k % 7 + 1);
            end
        end
        @(negedge clk);
        tests_run++;
        if (draw_done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_after_done: got done=%b busy=%b required 0 0", draw_done, busy);
        end
    endtask

    task automatic test_flip();
        int cyc, n, nhi, base, a;
        logic [AW-1:0] fa;
        logic [KW-1:0] gc;
        load_rom(0);
        do_draw(10, 20, 1, 1, 0, cyc, n, nhi, base, fa);
        tests_run++;
        if (cyc != 34 || n != 16 || fa !== AW'(15)) begin
            tests_failed++;
            $display("FAIL flip_hv_summary: got cycle=%0d plots=%0d addr0=%0d required 34 16 15", cyc, n, fa);
        end
        for (int k = 0; k < 16; k++) begin
            gc = (k < n) ? mc[base+k] : 'x;
            tests_run++;
            if (gc !== KW'((15 - k) % 7 + 1) || (k < n && mx[base+k] !== CW'(10 + k % 4))) begin
                tests_failed++;
                $display("FAIL flip_hv_pix%0d: got c%0d required c%0d", k, gc, (15 - k) % 7 + 1);
            end
        end
        do_draw(10, 20, 1, 0, 0, cyc, n, nhi, base, fa);
        tests_run++;
        if (cyc != 34 || n != 16 || fa !== AW'(3)) begin
            tests_failed++;
            $display("FAIL flip_h_summary: got cycle=%0d plots=%0d addr0=%0d required 34 16 3", cyc, n, fa);
        end
        for (int k = 0; k < 16; k++) begin
            a  = (k / 4) * 4 + (3 - k % 4);
            gc = (k < n) ? mc[base+k] : 'x;
            tests_run++;
            if (gc !== KW'(a % 7 + 1)) begin
                tests_failed++;
                $display("FAIL flip_h_pix%0d: got c%0d required c%0d", k, gc, a % 7 + 1);
            end
        end
    endtask

    task automatic test_color_key();
        int cyc, n, nhi, base, k;
        logic [AW-1:0] fa;
        logic [CW-1:0] gx, gy;
        logic [KW-1:0] gc;
        load_rom(1);
        do_draw(10, 20, 0, 0, 1, cyc, n, nhi, base, fa);
        tests_run++;
        if (cyc != 34 || n != 8 || nhi != 8) begin
            tests_failed++;
            $display("FAIL key_summary: got cycle=%0d plots=%0d plot_hi=%0d required 34 8 8", cyc, n, nhi);
        end
        for (int j = 0; j < 8; j++) begin
            k  = 2 * j + 1;
            gx = (j < n) ? mx[base+j] : 'x;
            gy = (j < n) ? my[base+j] : 'x;
            gc = (j < n) ? mc[base+j] : 'x;
            tests_run++;
            if (gx !== CW'(10 + k % 4) || gy !== CW'(20 + k / 4) || gc !== KW'(k % 7 + 1)) begin
                tests_failed++;
                $display("FAIL key_pix%0d: got (%0d,%0d) c%0d required (%0d,%0d) c%0d",
                         j, gx, gy, gc, 10 + k % 4, 20 + k / 4, k % 7 + 1);
            end
        end
        do_draw(10, 20, 0, 0, 0, cyc, n, nhi, base, fa);
        gc = (n > 0) ? mc[base] : 'x;
        tests_run++;
        if (n != 16 || gc !== KW'(0)) begin
            tests_failed++;
            $display("FAIL nokey_summary: got plots=%0d c0=%0d required 16 0", n, gc);
        end
    endtask

    task automatic test_clip();
        int cyc, n, nhi, base;
        logic [AW-1:0] fa;
        int ex[4] = '{638, 639, 638, 639};
        int ey[4] = '{478, 478, 479, 479};
        int ec[4] = '{1, 2, 5, 6};
        logic [CW-1:0] gx, gy;
        logic [KW-1:0] gc;
        load_rom(0);
        do_draw(638, 478, 0, 0, 0, cyc, n, nhi, base, fa);
        tests_run++;
        if (cyc != 34 || n != 4) begin
            tests_failed++;
            $display("FAIL clip_corner_summary: got cycle=%0d plots=%0d required 34 4", cyc, n);
        end
        for (int j = 0; j < 4; j++) begin
            gx = (j < n) ? mx[base+j] : 'x;
            gy = (j < n) ? my[base+j] : 'x;
            gc = (j < n) ? mc[base+j] : 'x;
            tests_run++;
            if (gx !== CW'(ex[j]) || gy !== CW'(ey[j]) || gc !== KW'(ec[j])) begin
                tests_failed++;
                $display("FAIL clip_corner_pix%0d: got (%0d,%0d) c%0d required (%0d,%0d) c%0d",
                         j, gx, gy, gc, ex[j], ey[j], ec[j]);
            end
        end
        do_draw(1022, 0, 0, 0, 0, cyc, n, nhi, base, fa);
        tests_run++;
        if (cyc != 34 || n != 0 || nhi != 0) begin
            tests_failed++;
            $display("FAIL clip_carry_x: got cycle=%0d plots=%0d required 34 0", cyc, n);
        end
        do_draw(0, 1022, 0, 0, 0, cyc, n, nhi, base, fa);
        tests_run++;
        if (cyc != 34 || n != 0) begin
            tests_failed++;
            $display("FAIL clip_carry_y: got cycle=%0d plots=%0d required 34 0", cyc, n);
        end
        do_draw(636, 476, 0, 0, 0, cyc, n, nhi, base, fa);
        tests_run++;
        if (n != 16) begin
            tests_failed++;
            $display("FAIL clip_exact_edge: got plots=%0d required 16", n);
        end
    endtask

    task automatic test_backpressure();
        int cyc, n, base, hi0;
        logic [KW-1:0] gc;
        load_rom(0);
        base = mx.size();
        hi0  = plot_hi;
        @(posedge clk); #1;
        x_pos = CW'(10); y_pos = CW'(20);
        flip_h = 1'b0; flip_v = 1'b0; key_en = 1'b0; plot_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (cyc < 200) begin
            plot_ready = (cyc >= 5 && cyc <= 7) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (cyc >= 5 && cyc <= 8) begin
                tests_run++;
                if (plot_out !== 1'b1 || x_pix !== CW'(11) || y_pix !== CW'(20) || color !== KW'(2)) begin
                    tests_failed++;
                    $display("FAIL stall_hold_c%0d: got plot=%b (%0d,%0d) c%0d required 1 (11,20) c2",
                             cyc, plot_out, x_pix, y_pix, color);
                end
            end
            if (draw_done === 1'b1) break;
            @(posedge clk); #1;
            cyc++;
        end
        plot_ready = 1'b1;
        n = mx.size() - base;
        $display("[TB] stalled draw (10,20): %0d plots, done at cycle %0d", n, cyc);
        tests_run++;
        if (cyc != 37 || n != 16 || plot_hi - hi0 != 19) begin
            tests_failed++;
            $display("FAIL stall_summary: got cycle=%0d plots=%0d plot_hi=%0d required 37 16 19",
                     cyc, n, plot_hi - hi0);
        end
        for (int k = 0; k < 16; k++) begin
            gc = (k < n) ? mc[base+k] : 'x;
            tests_run++;
            if (gc !== KW'(k % 7 + 1) || (k < n && mx[base+k] !== CW'(10 + k % 4))) begin
                tests_failed++;
                $display("FAIL stall_pix%0d: got c%0d required c%0d", k, gc, k % 7 + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, n, base, d1, d2;
        logic b35, b36;
        logic [AW-1:0] a36;
        load_rom(0);
        base = mx.size();
        d1 = 0; d2 = 0; b35 = 1'bx; b36 = 1'bx; a36 = 'x;
        @(posedge clk); #1;
        x_pos = CW'(10); y_pos = CW'(20);
        flip_h = 1'b0; flip_v = 1'b0; key_en = 1'b0; plot_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        cyc = 2;
        while (cyc < 200 && d2 == 0) begin
            @(negedge clk);
            if (draw_done === 1'b1) begin
                if (d1 == 0) d1 = cyc;
                else d2 = cyc;
            end
            if (cyc == 35) b35 = busy;
            if (cyc == 36) begin
                b36 = busy;
                a36 = rom_addr;
            end
            @(posedge clk); #1;
            if (cyc == 36) start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        n = mx.size() - base;
        $display("[TB] held-start draws (10,20): %0d plots, done at cycles %0d and %0d", n, d1, d2);
        tests_run++;
        if (d1 != 34 || d2 != 68 || n != 32) begin
            tests_failed++;
            $display("FAIL b2b_timing: got done1=%0d done2=%0d plots=%0d required 34 68 32", d1, d2, n);
        end
        tests_run++;
        if (b35 !== 1'b0 || b36 !== 1'b1 || a36 !== AW'(0)) begin
            tests_failed++;
            $display("FAIL b2b_restart: got busy35=%b busy36=%b addr36=%0d required 0 1 0", b35, b36, a36);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, n, nhi, base, base0;
        logic [AW-1:0] fa;
        logic [CW-1:0] gx, gy;
        logic [KW-1:0] gc;
        load_rom(0);
        base0 = mx.size();
        @(posedge clk); #1;
        x_pos = CW'(10); y_pos = CW'(20);
        flip_h = 1'b1; flip_v = 1'b0; key_en = 1'b0; plot_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (cyc < 13) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (plot_out !== 1'b1 || x_pix !== CW'(11) || y_pix !== CW'(21) || color !== KW'(7)) begin
            tests_failed++;
            $display("FAIL midreset_pix5: got plot=%b (%0d,%0d) c%0d required 1 (11,21) c7",
                     plot_out, x_pix, y_pix, color);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({plot_out, busy, draw_done} !== 3'b000 || rom_addr !== '0 ||
            x_pix !== '0 || y_pix !== '0 || color !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got plot=%b busy=%b done=%b addr=%0d x=%0d y=%0d c=%0d required all zero",
                     plot_out, busy, draw_done, rom_addr, x_pix, y_pix, color);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n = mx.size() - base0;
        $display("[TB] draw (10,20) fh=1 aborted by reset: %0d plots", n);
        tests_run++;
        if (n != 5 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_abandon: got plots=%0d busy=%b required 5 0", n, busy);
        end
        do_draw(10, 20, 0, 0, 0, cyc, n, nhi, base, fa);
        gx = (n > 0) ? mx[base] : 'x;
        gy = (n > 0) ? my[base] : 'x;
        gc = (n > 0) ? mc[base] : 'x;
        tests_run++;
        if (cyc != 34 || n != 16 || gx !== CW'(10) || gy !== CW'(20) || gc !== KW'(1)) begin
            tests_failed++;
            $display("FAIL midreset_redraw: got cycle=%0d plots=%0d first=(%0d,%0d) c%0d required 34 16 (10,20) c1",
                     cyc, n, gx, gy, gc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_color_key();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
